// File: rtl/nn_rnn_bptt_history_lifo.sv
// rtl/nn_rnn_bptt_history_lifo.sv - BPTT forward-history LIFO: records z/zp window counts, replays them newest-first as bitstreams
module nn_rnn_bptt_history_lifo #(
    parameter int              W     = 8,
    parameter int              DEPTH = 16,
    parameter int              PTR_W = 4,
    parameter logic [W-1:0]    DECOR = W'(8'hA5)
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             CLEAR,
    input  logic             MODE,
    input  logic             STEP,
    input  logic             z_in,
    input  logic             zp_in,
    output logic             z_out,
    output logic             zp_out,
    output logic             BUSY,
    output logic             STEP_DONE,
    output logic [PTR_W:0]   COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVF
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REC    = 2'd1,
        S_REPLAY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     cyc;
    logic [W:0]       cz;
    logic [W:0]       czp;
    logic [W:0]       rz;
    logic [W:0]       rzp;
    logic [PTR_W:0]   ptr;
    logic             ovf;
    logic             done_q;
    logic [2*W+1:0]   mem [DEPTH];

    logic             last_cyc;
    logic             push_ok;
    logic             pop_ok;
    logic [W:0]       cz_nxt;
    logic [W:0]       czp_nxt;
    logic [W-1:0]     brev;
    logic [PTR_W-1:0] rd_idx;

    // Bit-reversed window index spreads replayed ones evenly across the window
    function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = v[W-1-i];
        end
        return r;
    endfunction

    assign last_cyc = (cyc == {W{1'b1}});
    assign push_ok  = STEP && !MODE && !FULL;
    assign pop_ok   = STEP && MODE && !EMPTY;
    assign cz_nxt   = cz + (W+1)'(z_in);
    assign czp_nxt  = czp + (W+1)'(zp_in);
    assign brev     = bitrev(cyc);
    assign rd_idx   = ptr[PTR_W-1:0] - PTR_W'(1);

    assign BUSY      = (state != S_IDLE);
    assign STEP_DONE = done_q;
    assign COUNT     = ptr;
    assign EMPTY     = (ptr == '0);
    assign FULL      = (ptr == (PTR_W+1)'(DEPTH));
    assign OVF       = ovf;

    // Next-state decode and replay bitstream generation
    always_comb begin
        state_nxt = state;
        z_out     = 1'b0;
        zp_out    = 1'b0;
        case (state)
            S_IDLE: begin
                if (push_ok) begin
                    state_nxt = S_REC;
                end else if (pop_ok) begin
                    state_nxt = S_REPLAY;
                end
            end
            S_REC: begin
                if (last_cyc) begin
                    state_nxt = S_IDLE;
                end
            end
            S_REPLAY: begin
                z_out  = ({1'b0, brev} < rz);
                zp_out = ({1'b0, brev ^ DECOR} < rzp);
                if (last_cyc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, window counters, LIFO pointer and sticky overflow flag
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state  <= S_IDLE;
            cyc    <= '0;
            cz     <= '0;
            czp    <= '0;
            rz     <= '0;
            rzp    <= '0;
            ptr    <= '0;
            ovf    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (STEP) begin
                        if (push_ok) begin
                            cz  <= '0;
                            czp <= '0;
                            cyc <= '0;
                        end else if (pop_ok) begin
                            rz  <= mem[rd_idx][2*W+1:W+1];
                            rzp <= mem[rd_idx][W:0];
                            ptr <= ptr - (PTR_W+1)'(1);
                            cyc <= '0;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (CLEAR) begin
                        ptr <= '0;
                        ovf <= 1'b0;
                    end
                end
                S_REC: begin
                    cz  <= cz_nxt;
                    czp <= czp_nxt;
                    cyc <= cyc + W'(1);
                    if (last_cyc) begin
                        ptr    <= ptr + (PTR_W+1)'(1);
                        done_q <= 1'b1;
                    end
                end
                S_REPLAY: begin
                    cyc <= cyc + W'(1);
                    if (last_cyc) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // History storage; counts include the final sample of the window
    always_ff @(posedge CLK) begin
        if (state == S_REC && last_cyc) begin
            mem[ptr[PTR_W-1:0]] <= {cz_nxt, czp_nxt};
        end
    end

endmodule
